// File: rtl/encoder_led_ring_if.sv
// Step-strobe inputs, position readout and 74HC595-style serial LED bus for encoder_led_ring.
// The master side is the ring controller; the slave side is whatever drives steps and watches the LEDs.
interface encoder_led_ring_if #(
  parameter int unsigned NUM_LEDS = 18
);
  localparam int unsigned POS_W = $clog2(2 * NUM_LEDS + 1);

  logic             step_cw;
  logic             step_ccw;
  logic [POS_W-1:0] pos;
  logic             sclk;
  logic             sdata;
  logic             rclk;
  logic             busy;

  modport master (
    input  step_cw, step_ccw,
    output pos, sclk, sdata, rclk, busy
  );

  modport slave (
    output step_cw, step_ccw,
    input  pos, sclk, sdata, rclk, busy
  );
endinterface

// File: rtl/encoder_led_ring.sv
// Saturating encoder position rendered as an LED bar graph and shifted out MSB-first
// to a serial-in/parallel-out LED driver, re-sent whenever the displayed pattern changes.
module encoder_led_ring #(
  parameter int unsigned NUM_LEDS = 18,
  parameter int unsigned INIT_POS = 18,
  parameter int unsigned CLK_DIV  = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  encoder_led_ring_if.master  bus
);
  localparam int unsigned POS_MAX = 2 * NUM_LEDS;
  localparam int unsigned POS_W   = $clog2(POS_MAX + 1);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [POS_W-1:0] POS_MAX_V = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_INIT  = POS_W'(INIT_POS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH
  } state_e;

  state_e              state_q;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                pending_q, pending_d;
  logic [NUM_LEDS-1:0] pattern, pattern_next;
  logic [NUM_LEDS-1:0] shreg_q, shreg_shl;
  logic [BIT_W-1:0]    bit_q;
  logic [DIV_W-1:0]    div_q;
  logic                sclk_q, sdata_q, rclk_q, busy_q;

  // LED i is lit when i < (pos+1)/2, so each LED spans two detents.
  function automatic logic [NUM_LEDS-1:0] bar(input logic [POS_W-1:0] p);
    logic [POS_W:0]      lit;
    logic [NUM_LEDS-1:0] leds;
    lit  = ({1'b0, p} + (POS_W+1)'(1)) >> 1;
    leds = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      leds[i] = (i < 32'(lit));
    end
    return leds;
  endfunction

  always_comb begin
    pos_d = pos_q;
    if (bus.step_cw && !bus.step_ccw && (pos_q != POS_MAX_V)) begin
      pos_d = pos_q + POS_W'(1);
    end else if (bus.step_ccw && !bus.step_cw && (pos_q != '0)) begin
      pos_d = pos_q - POS_W'(1);
    end
  end

  assign pattern      = bar(pos_q);
  assign pattern_next = bar(pos_d);
  assign shreg_shl    = shreg_q << 1;

  // A change seen during LOAD must survive the clear: the snapshot already holds the old pattern.
  always_comb begin
    pending_d = pending_q;
    if (pattern_next != pattern) begin
      pending_d = 1'b1;
    end else if (state_q == S_LOAD) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q     <= POS_INIT;
      pending_q <= 1'b1;
    end else begin
      pos_q     <= pos_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      rclk_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end

        S_LOAD: begin
          shreg_q <= pattern;
          bit_q   <= BIT_LAST;
          div_q   <= '0;
          sclk_q  <= 1'b0;
          sdata_q <= pattern[NUM_LEDS-1];
          state_q <= S_SHIFT_LO;
        end

        S_SHIFT_LO: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= S_SHIFT_HI;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        S_SHIFT_HI: begin
          if (div_q == DIV_LAST) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            if (bit_q == '0) begin
              rclk_q  <= 1'b1;
              state_q <= S_LATCH;
            end else begin
              shreg_q <= shreg_shl;
              sdata_q <= shreg_shl[NUM_LEDS-1];
              bit_q   <= bit_q - BIT_W'(1);
              state_q <= S_SHIFT_LO;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        S_LATCH: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            rclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        default: begin
          sclk_q  <= 1'b0;
          rclk_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pos   = pos_q;
  assign bus.sclk  = sclk_q;
  assign bus.sdata = sdata_q;
  assign bus.rclk  = rclk_q;
  assign bus.busy  = busy_q;
endmodule
